// File: rtl/uart_cmd_frame_tx_pkg.sv
// Shared constants and types for the diff_freq_serial_out command-frame initiator:
// command codes, request encodings, frame lengths and the DATA control-byte layout.
package uart_cmd_frame_tx_pkg;

   localparam logic [7:0] CmdFreqDefault   = 8'hA1;
   localparam logic [7:0] CmdPeriodDefault = 8'hA2;
   localparam logic [7:0] CmdDataDefault   = 8'hA3;

   typedef enum logic [1:0] {
      ReqFreq    = 2'd0,
      ReqPeriod  = 2'd1,
      ReqData    = 2'd2,
      ReqIllegal = 2'd3
   } req_type_e;

   localparam int unsigned FreqLen   = 5;
   localparam int unsigned PeriodLen = 3;
   localparam int unsigned DataLen   = 6;

   // Control byte: channel [7:4], reserved [3], mode [2], tag [1:0]
   localparam logic [1:0] CtrlTag = 2'b01;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StWaitDone,
      StGap,
      StDone
   } state_e;

   typedef struct packed {
      logic [1:0]  req_type;
      logic [31:0] pattern;
      logic [7:0]  slow;
      logic [7:0]  fast;
      logic [3:0]  channel;
      logic        mode;
   } frame_t;

   function automatic logic [2:0] last_idx(logic [1:0] req_type);
      logic [2:0] idx;
      unique case (req_type)
         ReqFreq:   idx = 3'(FreqLen - 1);
         ReqPeriod: idx = 3'(PeriodLen - 1);
         ReqData:   idx = 3'(DataLen - 1);
         default:   idx = 3'd0;
      endcase
      return idx;
   endfunction

   function automatic logic [7:0] ctrl_byte(logic [3:0] channel, logic mode);
      return {channel, 1'b0, mode, CtrlTag};
   endfunction

endpackage

// File: rtl/uart_cmd_byte_mux.sv
// Combinational byte selector: maps request fields, type and byte index to the byte
// that belongs at that position of the command frame.
module uart_cmd_byte_mux
   import uart_cmd_frame_tx_pkg::*;
#(
   parameter logic [7:0] CMD_FREQ   = CmdFreqDefault,
   parameter logic [7:0] CMD_PERIOD = CmdPeriodDefault,
   parameter logic [7:0] CMD_DATA   = CmdDataDefault
) (
   input  logic [1:0]  req_type_i,
   input  logic [31:0] pattern_i,
   input  logic [7:0]  slow_i,
   input  logic [7:0]  fast_i,
   input  logic [3:0]  channel_i,
   input  logic        mode_i,
   input  logic [2:0]  byte_idx_i,
   output logic [7:0]  tx_data_o
);

   logic [7:0] pat_byte;

   always_comb begin
      pat_byte = 8'h00;
      unique case (byte_idx_i)
         3'd1:    pat_byte = pattern_i[7:0];
         3'd2:    pat_byte = pattern_i[15:8];
         3'd3:    pat_byte = pattern_i[23:16];
         3'd4:    pat_byte = pattern_i[31:24];
         default: pat_byte = 8'h00;
      endcase
   end

   always_comb begin
      tx_data_o = 8'h00;
      unique case (req_type_i)
         ReqFreq: begin
            tx_data_o = (byte_idx_i == 3'd0) ? CMD_FREQ : pat_byte;
         end
         ReqPeriod: begin
            unique case (byte_idx_i)
               3'd0:    tx_data_o = CMD_PERIOD;
               3'd1:    tx_data_o = slow_i;
               3'd2:    tx_data_o = fast_i;
               default: tx_data_o = 8'h00;
            endcase
         end
         ReqData: begin
            if (byte_idx_i == 3'd0) begin
               tx_data_o = CMD_DATA;
            end else if (byte_idx_i == 3'd5) begin
               tx_data_o = ctrl_byte(channel_i, mode_i);
            end else begin
               tx_data_o = pat_byte;
            end
         end
         default: tx_data_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/uart_cmd_frame_tx.sv
// Command-frame initiator: accepts one FREQ/PERIOD/DATA request and serialises it byte by
// byte through a UART transmitter, with optional inter-byte gap and per-byte timeout.
module uart_cmd_frame_tx
   import uart_cmd_frame_tx_pkg::*;
#(
   parameter logic [7:0]  CMD_FREQ       = CmdFreqDefault,
   parameter logic [7:0]  CMD_PERIOD     = CmdPeriodDefault,
   parameter logic [7:0]  CMD_DATA       = CmdDataDefault,
   parameter int unsigned GAP_CYCLES     = 0,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [1:0]  req_type_i,
   input  logic [31:0] req_pattern_i,
   input  logic [7:0]  req_slow_i,
   input  logic [7:0]  req_fast_i,
   input  logic [3:0]  req_channel_i,
   input  logic        req_mode_i,
   output logic        tx_start_o,
   output logic [7:0]  tx_data_o,
   input  logic        tx_done_tick_i,
   output logic        busy_o,
   output logic        frame_done_tick_o,
   output logic        err_tick_o
);

   state_e      state_q;
   frame_t      frame_q;
   logic [2:0]  idx_q;
   logic [31:0] gap_cnt_q;
   logic [31:0] to_cnt_q;
   logic        ready_q, start_q, busy_q, done_q, err_q;
   logic [7:0]  data_q;

   logic [1:0]  sel_type;
   logic [31:0] sel_pattern;
   logic [7:0]  sel_slow, sel_fast;
   logic [3:0]  sel_channel;
   logic        sel_mode;
   logic [2:0]  sel_idx;
   logic [7:0]  mux_byte;

   // The mux always presents the byte the next START will load: byte 0 of the incoming
   // request while accepting, the following byte while waiting on the UART.
   always_comb begin
      sel_type    = frame_q.req_type;
      sel_pattern = frame_q.pattern;
      sel_slow    = frame_q.slow;
      sel_fast    = frame_q.fast;
      sel_channel = frame_q.channel;
      sel_mode    = frame_q.mode;
      sel_idx     = idx_q;
      if (state_q == StIdle || state_q == StDone) begin
         sel_type    = req_type_i;
         sel_pattern = req_pattern_i;
         sel_slow    = req_slow_i;
         sel_fast    = req_fast_i;
         sel_channel = req_channel_i;
         sel_mode    = req_mode_i;
         sel_idx     = 3'd0;
      end else if (state_q == StWaitDone) begin
         sel_idx = idx_q + 3'd1;
      end
   end

   uart_cmd_byte_mux #(
      .CMD_FREQ   (CMD_FREQ),
      .CMD_PERIOD (CMD_PERIOD),
      .CMD_DATA   (CMD_DATA)
   ) u_byte_mux (
      .req_type_i (sel_type),
      .pattern_i  (sel_pattern),
      .slow_i     (sel_slow),
      .fast_i     (sel_fast),
      .channel_i  (sel_channel),
      .mode_i     (sel_mode),
      .byte_idx_i (sel_idx),
      .tx_data_o  (mux_byte)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         frame_q   <= '0;
         idx_q     <= 3'd0;
         gap_cnt_q <= '0;
         to_cnt_q  <= '0;
         ready_q   <= 1'b1;
         start_q   <= 1'b0;
         data_q    <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               state_q <= StIdle;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               idx_q   <= 3'd0;
               if (req_valid_i) begin
                  frame_q.req_type <= req_type_i;
                  frame_q.pattern  <= req_pattern_i;
                  frame_q.slow     <= req_slow_i;
                  frame_q.fast     <= req_fast_i;
                  frame_q.channel  <= req_channel_i;
                  frame_q.mode     <= req_mode_i;
                  if (req_type_i == ReqIllegal) begin
                     err_q <= 1'b1;
                  end else begin
                     state_q <= StStart;
                     start_q <= 1'b1;
                     data_q  <= mux_byte;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                  end
               end
            end
            StStart: begin
               state_q  <= StWaitDone;
               to_cnt_q <= 32'd1;
            end
            StWaitDone: begin
               to_cnt_q <= to_cnt_q + 32'd1;
               if (tx_done_tick_i) begin
                  if (idx_q == last_idx(frame_q.req_type)) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                     ready_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                     if (GAP_CYCLES > 0) begin
                        state_q   <= StGap;
                        gap_cnt_q <= '0;
                     end else begin
                        state_q <= StStart;
                        start_q <= 1'b1;
                        data_q  <= mux_byte;
                     end
                  end
               end else if (TIMEOUT_CYCLES != 0 && (to_cnt_q + 32'd1) >= TIMEOUT_CYCLES) begin
                  state_q <= StIdle;
                  err_q   <= 1'b1;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  idx_q   <= 3'd0;
               end
            end
            StGap: begin
               gap_cnt_q <= gap_cnt_q + 32'd1;
               if (gap_cnt_q == GAP_CYCLES - 1) begin
                  state_q <= StStart;
                  start_q <= 1'b1;
                  data_q  <= mux_byte;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready_o       = ready_q;
   assign tx_start_o        = start_q;
   assign tx_data_o         = data_q;
   assign busy_o            = busy_q;
   assign frame_done_tick_o = done_q;
   assign err_tick_o        = err_q;

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Randomised bench for uart_cmd_frame_tx: two instances (no gap / short timeout, and
// three-cycle gap) driven by a UART responder and checked against a frame-level model.
module tb_uart_cmd_frame_tx;

   typedef struct {
      int          t;
      logic [31:0] pat;
      logic [7:0]  slow;
      logic [7:0]  fast;
      logic [3:0]  ch;
      logic        mode;
   } req_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic        rst0 = 1'b0, rst1 = 1'b0;
   logic        done0 = 1'b0, done1 = 1'b0;
   logic        stall0 = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_mode  = '0;
   logic [1:0]  req_type    [2];
   logic [31:0] req_pattern [2];
   logic [7:0]  req_slow    [2];
   logic [7:0]  req_fast    [2];
   logic [3:0]  req_ch      [2];
   logic [1:0]  ready, tx_start, busy, fdone, err;
   logic [7:0]  tx_data [2];

   int done_cyc0 = 0, done_cyc1 = 0;
   int cnt0 = -1, cnt1 = -1;
   logic [7:0] got_q [2][$];

   uart_cmd_frame_tx #(
      .CMD_FREQ(8'hA1), .CMD_PERIOD(8'hA2), .CMD_DATA(8'hA3),
      .GAP_CYCLES(0), .TIMEOUT_CYCLES(20)
   ) dut0 (
      .clk_i(clk), .rst_ni(rst0), .req_valid_i(req_valid[0]), .req_ready_o(ready[0]),
      .req_type_i(req_type[0]), .req_pattern_i(req_pattern[0]), .req_slow_i(req_slow[0]),
      .req_fast_i(req_fast[0]), .req_channel_i(req_ch[0]), .req_mode_i(req_mode[0]),
      .tx_start_o(tx_start[0]), .tx_data_o(tx_data[0]), .tx_done_tick_i(done0),
      .busy_o(busy[0]), .frame_done_tick_o(fdone[0]), .err_tick_o(err[0])
   );

   uart_cmd_frame_tx #(
      .CMD_FREQ(8'h5A), .CMD_PERIOD(8'h5B), .CMD_DATA(8'h5C),
      .GAP_CYCLES(3), .TIMEOUT_CYCLES(65535)
   ) dut1 (
      .clk_i(clk), .rst_ni(rst1), .req_valid_i(req_valid[1]), .req_ready_o(ready[1]),
      .req_type_i(req_type[1]), .req_pattern_i(req_pattern[1]), .req_slow_i(req_slow[1]),
      .req_fast_i(req_fast[1]), .req_channel_i(req_ch[1]), .req_mode_i(req_mode[1]),
      .tx_start_o(tx_start[1]), .tx_data_o(tx_data[1]), .tx_done_tick_i(done1),
      .busy_o(busy[1]), .frame_done_tick_o(fdone[1]), .err_tick_o(err[1])
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] cmd_of(int k, int t);
      logic [7:0] c;
      if (k == 0) c = (t == 0) ? 8'hA1 : (t == 1) ? 8'hA2 : 8'hA3;
      else        c = (t == 0) ? 8'h5A : (t == 1) ? 8'h5B : 8'h5C;
      return c;
   endfunction

   function automatic int gap_of(int k);
      return (k == 0) ? 0 : 3;
   endfunction

   function automatic int done_cyc_of(int k);
      return (k == 0) ? done_cyc0 : done_cyc1;
   endfunction

   // Reference frame: bytes the receiver expects for a request, byte 0 first.
   function automatic int build(int k, req_t r, output logic [7:0] b [6]);
      int len;
      for (int i = 0; i < 6; i++) b[i] = 8'h00;
      len = 0;
      if (r.t == 0 || r.t == 2) begin
         b[0] = cmd_of(k, r.t);
         for (int i = 0; i < 4; i++) b[i + 1] = 8'((r.pat >> (8 * i)) & 32'hFF);
         len = 5;
         if (r.t == 2) begin
            b[5] = 8'(int'(r.ch) * 16 + (r.mode ? 4 : 0) + 1);
            len = 6;
         end
      end else if (r.t == 1) begin
         b[0] = cmd_of(k, 1);
         b[1] = r.slow;
         b[2] = r.fast;
         len = 3;
      end
      return len;
   endfunction

   // UART responders: done tick a few cycles after each start, sometimes a stray tick
   // during the start cycle itself, which the DUT must ignore.
   initial forever begin
      @(negedge clk);
      done0 = 1'b0;
      if (cnt0 == 0) begin
         done0 = 1'b1; done_cyc0 = cyc; cnt0 = -1;
      end else if (cnt0 > 0) cnt0--;
      if (tx_start[0] && !stall0) begin
         cnt0 = $urandom_range(1, 5);
         if ($urandom_range(0, 3) == 0) done0 = 1'b1;
      end
   end

   initial forever begin
      @(negedge clk);
      done1 = 1'b0;
      if (cnt1 == 0) begin
         done1 = 1'b1; done_cyc1 = cyc; cnt1 = -1;
      end else if (cnt1 > 0) cnt1--;
      if (tx_start[1]) begin
         cnt1 = $urandom_range(1, 5);
         if ($urandom_range(0, 3) == 0) done1 = 1'b1;
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (tx_start[k]) begin
            if (got_q[k].size() > 0)
               check("gap_done_to_start", 64'(cyc - done_cyc_of(k)), 64'(gap_of(k) + 1));
            got_q[k].push_back(tx_data[k]);
            check("busy_on_start", busy[k], 1'b1);
         end
         if (fdone[k]) begin
            check("frame_done_latency", 64'(cyc - done_cyc_of(k)), 64'd1);
            check("ready_on_frame_done", ready[k], 1'b1);
         end
      end
   end

   task automatic drive(int k, req_t r, logic v);
      req_type[k]    = 2'(r.t);
      req_pattern[k] = r.pat;
      req_slow[k]    = r.slow;
      req_fast[k]    = r.fast;
      req_ch[k]      = r.ch;
      req_mode[k]    = r.mode;
      req_valid[k]   = v;
   endtask

   task automatic check_reset_vals(int k, string tag);
      check({tag, "_ready"}, ready[k], 1'b1);
      check({tag, "_start"}, tx_start[k], 1'b0);
      check({tag, "_data"}, tx_data[k], 8'h00);
      check({tag, "_busy"}, busy[k], 1'b0);
      check({tag, "_fdone"}, fdone[k], 1'b0);
      check({tag, "_err"}, err[k], 1'b0);
   endtask

   // Called just after a negedge; returns at the negedge of cycle T+1.
   task automatic accept(int k, req_t r, output int t);
      int n = 0;
      got_q[k].delete();
      drive(k, r, 1'b1);
      while (!ready[k] && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait_bound", ready[k], 1'b1);
      t = cyc;
      @(negedge clk);
      req_valid[k] = 1'b0;
      if (r.t == 3) begin
         check("illegal_err_t1", err[k], 1'b1);
         check("illegal_ready_t1", ready[k], 1'b1);
         check("illegal_busy_t1", busy[k], 1'b0);
         check("illegal_no_start_t1", tx_start[k], 1'b0);
      end else begin
         check("first_start_t1", tx_start[k], 1'b1);
         check("ready_low_t1", ready[k], 1'b0);
         check("busy_t1", busy[k], 1'b1);
         check("err_quiet_t1", err[k], 1'b0);
      end
   endtask

   task automatic finish(int k, req_t r);
      logic [7:0] b [6];
      int len, n;
      len = build(k, r, b);
      if (r.t == 3) begin
         repeat (4) @(negedge clk);
         check("illegal_no_bytes", 64'(got_q[k].size()), 64'd0);
         check("illegal_busy_after", busy[k], 1'b0);
         return;
      end
      n = 0;
      while (!fdone[k] && !err[k] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("frame_done_seen", fdone[k], 1'b1);
      check("byte_count", 64'(got_q[k].size()), 64'(len));
      for (int i = 0; i < len && i < got_q[k].size(); i++)
         check($sformatf("byte%0d_k%0d_t%0d", i, k, r.t), got_q[k][i], b[i]);
   endtask

   task automatic run(int k, req_t r);
      int t;
      accept(k, r, t);
      finish(k, r);
   endtask

   initial begin
      req_t r, r2;
      int   t, s;
      for (int k = 0; k < 2; k++) drive(k, '{0, 32'h0, 8'h0, 8'h0, 4'h0, 1'b0}, 1'b0);
      repeat (3) @(negedge clk);
      rst0 = 1'b1;
      rst1 = 1'b1;
      check_reset_vals(0, "reset0");
      check_reset_vals(1, "reset1");
      @(negedge clk);

      run(0, '{0, 32'h5555_5555, 8'h00, 8'h00, 4'h0, 1'b0});

      // PERIOD, then DATA held valid must be taken the cycle frame_done shows ready.
      r  = '{1, 32'h0, 8'h14, 8'h05, 4'h0, 1'b0};
      r2 = '{2, 32'hCAFE_F00D, 8'h00, 8'h00, 4'h7, 1'b0};
      accept(0, r, t);
      drive(0, r2, 1'b1);
      finish(0, r);
      accept(0, r2, t);
      finish(0, r2);

      run(1, '{2, 32'h1234_5678, 8'h00, 8'h00, 4'hF, 1'b1});
      run(1, '{2, 32'h0BAD_BEEF, 8'h00, 8'h00, 4'hF, 1'b0});
      run(0, '{3, 32'hFFFF_FFFF, 8'hFF, 8'hFF, 4'hF, 1'b1});

      // Timeout: no done tick ever arrives.
      stall0 = 1'b1;
      accept(0, '{0, 32'h0102_0304, 8'h00, 8'h00, 4'h0, 1'b0}, t);
      s = cyc;
      begin
         int n = 0;
         while (!err[0] && !fdone[0] && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      check("timeout_err", err[0], 1'b1);
      check("timeout_no_frame_done", fdone[0], 1'b0);
      check("timeout_latency", 64'(cyc - s), 64'd20);
      check("timeout_busy", busy[0], 1'b0);
      check("timeout_ready", ready[0], 1'b1);
      stall0 = 1'b0;
      repeat (3) @(negedge clk);
      run(0, '{1, 32'h0, 8'hA5, 8'h5A, 4'h0, 1'b0});

      // Reset in the middle of a DATA frame.
      accept(1, '{2, 32'h8765_4321, 8'h00, 8'h00, 4'h3, 1'b1}, t);
      repeat (6) @(negedge clk);
      rst1 = 1'b0;
      @(negedge clk);
      check_reset_vals(1, "midreset");
      rst1 = 1'b1;
      repeat (10) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         int k, ty;
         k  = i % 2;
         ty = $urandom_range(0, 9);
         ty = (ty == 9) ? 3 : ty % 3;
         r = '{ty, $urandom, 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom)};
         run(k, r);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
